// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT front end:
//   - default sample width, frame size and drop-counter width
//   - read-side state encoding used by fft_frame_buffer
//   - bitrev(): reverses the low n bits of an index. It is shared with the
//     FFT core's address generator, which must use the same permutation.
// No ports (package).
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_DATA_W     = 8;
  localparam int FFT_LOG2_N     = 7;
  localparam int FFT_CNT_W      = 16;

  // Widest index bitrev() handles; callers truncate the result to LOG2_N bits.
  localparam int FFT_MAX_LOG2_N = 16;
  localparam int FFT_IDX_W      = $clog2(FFT_MAX_LOG2_N);

  // Read-side ownership of the bank not being written.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,  // no frame handed to the FFT
    RD_GO   = 2'd1,  // bank just swapped, fft_go asserted
    RD_BUSY = 2'd2   // FFT owns the read bank until fft_done
  } rd_state_e;

  // Reverse bits [n-1:0] of addr; bits at and above n return 0.
  function automatic logic [FFT_MAX_LOG2_N-1:0] bitrev(
    input logic [FFT_MAX_LOG2_N-1:0] addr,
    input int unsigned               n
  );
    logic [FFT_MAX_LOG2_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_MAX_LOG2_N; i++) begin
      if (i < n) r[FFT_IDX_W'(i)] = addr[FFT_IDX_W'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// fft_frame_buffer_if
// Bundles the sample stream, FFT launch/release handshake, FFT read port
// and drop counter of fft_frame_buffer.
//   slave  : the frame buffer (consumes samples, serves reads)
//   master : the environment (sample source + FFT core)
// Signals:
//   in_valid/in_data/in_ready : natural-order signed sample stream
//   fft_go / fft_done         : launch pulse out, bank release pulse in
//   rd_addr / rd_data         : FFT read index and 1-cycle-latency read data
//   rd_busy                   : read bank owned by the FFT
//   drop_cnt                  : saturating count of discarded samples
// -----------------------------------------------------------------------------
interface fft_frame_buffer_if
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2_N = FFT_LOG2_N,
  parameter int CNT_W  = FFT_CNT_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              fft_go;
  logic              fft_done;
  logic [LOG2_N-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_busy;
  logic [CNT_W-1:0]  drop_cnt;

  modport slave (
    input  in_valid, in_data, fft_done, rd_addr,
    output in_ready, fft_go, rd_data, rd_busy, drop_cnt
  );

  modport master (
    output in_valid, in_data, fft_done, rd_addr,
    input  in_ready, fft_go, rd_data, rd_busy, drop_cnt
  );

endinterface

// File: rtl/fft_dpram.sv
// -----------------------------------------------------------------------------
// fft_dpram
// Simple dual-port RAM, 2^ADDR_W x DATA_W: one write port and one registered
// read port. The shape is chosen so that it maps onto block RAM.
// Ports:
//   clk, rst_n : clock, async active-low reset (output register only)
//   we, waddr, wdata : write port
//   raddr, rdata     : read address, registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module fft_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array is deliberately left out of reset; a reset on
  // every word would prevent block-RAM mapping, and a frame is always fully
  // rewritten before it is handed to the FFT.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb rd_data_d = mem[raddr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// fft_frame_buffer
// Ping-pong input frame buffer between the sample source and the FFT core.
// Samples arrive in natural order and fill one bank of N = 2^LOG2_N words
// while the FFT reads the other. A completed frame swaps the banks and
// launches the FFT with a one-cycle fft_go. The FFT releases its bank with
// fft_done. If a second frame completes before the release, it is held
// (wr_full). Further samples are then refused (DROP_MODE=0) or discarded
// and counted (DROP_MODE=1).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : fft_frame_buffer_if.slave (stream in, FFT handshake, read
//                port, drop counter)
// Parameters: DATA_W, LOG2_N, BITREV (bit-reversed read index), DROP_MODE,
//             CNT_W (drop counter width).
// -----------------------------------------------------------------------------
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_DATA_W,
  parameter int LOG2_N    = FFT_LOG2_N,
  parameter bit BITREV    = 1'b1,
  parameter bit DROP_MODE = 1'b0,
  parameter int CNT_W     = FFT_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  fft_frame_buffer_if.slave   bus
);

  // Write side
  logic [LOG2_N-1:0] wr_cnt_q,   wr_cnt_d;
  logic              wr_bank_q,  wr_bank_d;
  logic              wr_full_q,  wr_full_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Read side
  rd_state_e         rd_state_q, rd_state_d;

  logic              rd_bank;
  logic              rd_busy;
  logic              in_ready;
  logic              accept;
  logic              frame_done;
  logic              bank_release;
  logic              swap;
  logic              drop_hit;
  logic [LOG2_N-1:0] rd_idx;

  // The two banks are always opposite, so the read bank is derived rather
  // than stored; "rd_bank <= wr_bank" at a swap is the same as flipping it.
  assign rd_bank  = ~wr_bank_q;
  assign rd_busy  = (rd_state_q != RD_IDLE);
  assign in_ready = DROP_MODE ? 1'b1 : ~wr_full_q;

  assign accept       = bus.in_valid & in_ready & ~wr_full_q;
  assign frame_done   = accept & (&wr_cnt_q);
  // fft_done only counts while the FFT actually owns a bank.
  assign bank_release = bus.fft_done & rd_busy;
  // A finished frame swaps at once if the read bank is free (or being freed
  // this cycle); a held frame swaps as soon as the FFT releases its bank.
  assign swap         = (frame_done & (~rd_busy | bus.fft_done))
                      | (wr_full_q & bank_release);
  assign drop_hit     = DROP_MODE & bus.in_valid & wr_full_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_full_d  = wr_full_q;
    drop_cnt_d = drop_cnt_q;
    rd_state_d = rd_state_q;

    // wr_cnt wraps N-1 -> 0 naturally, so a completed frame leaves it at 0
    // whether the swap happens now or later.
    if (accept) wr_cnt_d = wr_cnt_q + 1'b1;

    if (drop_hit && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;

    if (swap) begin
      wr_bank_d  = ~wr_bank_q;
      wr_full_d  = 1'b0;
      rd_state_d = RD_GO;
    end else begin
      if (frame_done) wr_full_d = 1'b1;
      if (bank_release)              rd_state_d = RD_IDLE;
      else if (rd_state_q == RD_GO)  rd_state_d = RD_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      wr_full_q  <= 1'b0;
      drop_cnt_q <= '0;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      wr_full_q  <= wr_full_d;
      drop_cnt_q <= drop_cnt_d;
      rd_state_q <= rd_state_d;
    end
  end

  // The FFT asks for its inputs in bit-reversed order when BITREV is set.
  assign rd_idx = BITREV ? LOG2_N'(bitrev(FFT_MAX_LOG2_N'(bus.rd_addr), LOG2_N))
                         : bus.rd_addr;

  fft_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_N + 1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (bus.in_data),
    .raddr ({rd_bank, rd_idx}),
    .rdata (bus.rd_data)
  );

  assign bus.in_ready = in_ready;
  assign bus.fft_go   = (rd_state_q == RD_GO);
  assign bus.rd_busy  = rd_busy;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_buffer
// Directed bench for fft_frame_buffer. Three instances share one stimulus:
//   dut_a : BITREV=1, DROP_MODE=0 (defaults)
//   dut_b : BITREV=0, DROP_MODE=0
//   dut_c : BITREV=1, DROP_MODE=1
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fft_frame_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       fft_done = 1'b0;
  logic [6:0] rd_addr = '0;

  int n_checks = 0;
  int n_errors = 0;

  int go_cnt_a = 0, go_cnt_c = 0, low_cnt_a = 0, low_cnt_c = 0;
  int go_ref, low_ref;

  always #5 clk = ~clk;

  fft_frame_buffer_if #(.DATA_W(8), .LOG2_N(7), .CNT_W(16)) if_a ();
  fft_frame_buffer_if #(.DATA_W(8), .LOG2_N(7), .CNT_W(16)) if_b ();
  fft_frame_buffer_if #(.DATA_W(8), .LOG2_N(7), .CNT_W(16)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_data = in_data;
  assign if_a.fft_done = fft_done;  assign if_a.rd_addr = rd_addr;
  assign if_b.in_valid = in_valid;  assign if_b.in_data = in_data;
  assign if_b.fft_done = fft_done;  assign if_b.rd_addr = rd_addr;
  assign if_c.in_valid = in_valid;  assign if_c.in_data = in_data;
  assign if_c.fft_done = fft_done;  assign if_c.rd_addr = rd_addr;

  fft_frame_buffer #(.DATA_W(8), .LOG2_N(7), .BITREV(1'b1), .DROP_MODE(1'b0), .CNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fft_frame_buffer #(.DATA_W(8), .LOG2_N(7), .BITREV(1'b0), .DROP_MODE(1'b0), .CNT_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  fft_frame_buffer #(.DATA_W(8), .LOG2_N(7), .BITREV(1'b1), .DROP_MODE(1'b1), .CNT_W(16))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Pulse and stall counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (if_a.fft_go)    go_cnt_a++;
    if (if_c.fft_go)    go_cnt_c++;
    if (!if_a.in_ready) low_cnt_a++;
    if (!if_c.in_ready) low_cnt_c++;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic done);
    in_valid = 1'b1;
    in_data  = v;
    fft_done = done;
    step();
    in_valid = 1'b0;
    fft_done = 1'b0;
  endtask

  task automatic pulse_done();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
  endtask

  task automatic read(input logic [6:0] a);
    rd_addr = a;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst in_ready",  if_a.in_ready, 1);
    check("rst fft_go",    if_a.fft_go,   0);
    check("rst rd_busy",   if_a.rd_busy,  0);
    check("rst rd_data",   $signed(if_a.rd_data), 0);
    check("rst drop_cnt",  if_c.drop_cnt, 0);

    // ---------------- ramp 0..127, first launch ----------------
    go_ref = go_cnt_a;
    for (int i = 0; i < 127; i++) push(8'(i), 1'b0);
    check("go before last", if_a.fft_go, 0);
    push(8'd127, 1'b0);
    check("go after last",   if_a.fft_go,  1);
    check("busy after last", if_a.rd_busy, 1);
    step();
    check("go one cycle",    if_a.fft_go,  0);
    check("busy held",       if_a.rd_busy, 1);
    check("go count ramp",   go_cnt_a - go_ref, 1);
    read(7'd1);
    check("bitrev addr1", $signed(if_a.rd_data), 64);
    rd_addr = 7'd127;
    #1;
    check("read latency hold", $signed(if_a.rd_data), 64);
    step();
    check("bitrev addr127", $signed(if_a.rd_data), 127);
    read(7'd5);
    check("bitrev addr5",  $signed(if_a.rd_data), 80);
    check("natural addr5", $signed(if_b.rd_data), 5);

    // ---------------- frame 1 ends together with fft_done ----------------
    low_ref = low_cnt_a;
    for (int i = 128; i < 256; i++) push(8'(i), (i == 255));
    check("simul go",       if_a.fft_go,   1);
    check("simul busy",     if_a.rd_busy,  1);
    check("simul in_ready", if_a.in_ready, 1);
    push(8'h11, 1'b0);
    check("simul go drop",  if_a.fft_go, 0);
    check("simul no stall", low_cnt_a - low_ref, 0);
    read(7'd0);
    check("simul addr0",   $signed(if_a.rd_data), -128);
    read(7'd127);
    check("simul addr127", $signed(if_a.rd_data), -1);
    pulse_done();
    check("done clears busy", if_a.rd_busy, 0);
    pulse_done();
    check("idle done busy", if_a.rd_busy, 0);
    check("idle done go",   if_a.fft_go,  0);

    // ---------------- backpressure / drop mode ----------------
    do_reset();
    low_ref = low_cnt_c;
    for (int i = 0; i < 255; i++) push(8'(i), 1'b0);
    check("bp ready before", if_a.in_ready, 1);
    push(8'd255, 1'b0);
    check("bp ready low",    if_a.in_ready, 0);
    check("drop ready high", if_c.in_ready, 1);
    for (int i = 0; i < 10; i++) push(8'hAA, 1'b0);
    check("bp still low",    if_a.in_ready, 0);
    check("bp drop_cnt",     if_a.drop_cnt, 0);
    check("drop_cnt 10",     if_c.drop_cnt, 10);
    pulse_done();
    check("bp go",           if_a.fft_go,   1);
    check("bp ready back",   if_a.in_ready, 1);
    check("bp busy",         if_a.rd_busy,  1);
    check("drop go",         if_c.fft_go,   1);
    read(7'd0);
    check("bp addr0",   $signed(if_a.rd_data), -128);
    check("drop addr0", $signed(if_c.rd_data), -128);
    check("drop never stalled", low_cnt_c - low_ref, 0);
    for (int i = 0; i < 128; i++) push(8'(i + 3), 1'b0);
    pulse_done();
    read(7'd0);
    check("drop next frame idx0", $signed(if_c.rd_data), 3);
    read(7'd1);
    check("drop next frame idx64", $signed(if_c.rd_data), 67);
    check("drop_cnt kept", if_c.drop_cnt, 10);

    // ---------------- reset mid-frame ----------------
    do_reset();
    for (int i = 0; i < 50; i++) push(8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid rst in_ready", if_a.in_ready, 1);
    check("mid rst busy",     if_a.rd_busy,  0);
    check("mid rst go",       if_a.fft_go,   0);
    check("mid rst rd_data",  $signed(if_a.rd_data), 0);
    step();
    rst_n = 1'b1;
    go_ref = go_cnt_a;
    for (int i = 0; i < 128; i++) push(8'(127 - i), 1'b0);
    step();
    step();
    check("mid go count", go_cnt_a - go_ref, 1);
    check("mid drop_cnt", if_c.drop_cnt, 0);
    read(7'd0);
    check("mid a idx0",  $signed(if_a.rd_data), 127);
    check("mid b idx0",  $signed(if_b.rd_data), 127);
    read(7'd70);
    check("mid a idx49", $signed(if_a.rd_data), 78);
    read(7'd49);
    check("mid b idx49", $signed(if_b.rd_data), 78);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Parametrised ping-pong input frame buffer sitting between the sample source and the FFT core.
- Accepts a signed sample stream in natural order and assembles frames of N = 2^LOG2_N samples into two alternating banks.
- Launches the FFT with a one-cycle fft_go pulse per completed frame.
- Serves the FFT core's reads with optional bit-reversed addressing. Replaces the fixed 8-bit/128-point direct feed, adding frame buffering, backpressure/drop modes and overflow accounting.

Parameters:
DATA_W, 8, sample width in bits (two's complement)
LOG2_N, 7, log2 of frame length (N = 128 by default)
BITREV, 1, 1 = rd_addr is bit-reversed before bank lookup; 0 = natural order
DROP_MODE, 0, 0 = backpressure via in_ready; 1 = in_ready tied high, samples arriving while both banks are busy are discarded and counted
CNT_W, 16, width of drop_cnt

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample valid
in_data  in  DATA_W  signed input sample
in_ready  out  1  buffer can accept a sample this cycle
fft_go  out  1  one-cycle start pulse to FFT core
fft_done  in  1  one-cycle pulse from FFT core: read bank released
rd_addr  in  LOG2_N  FFT core read index
rd_data  out  DATA_W  registered read data, 1-cycle latency
rd_busy  out  1  read bank owned by FFT (between go and done)
drop_cnt  out  CNT_W  saturating count of discarded samples (DROP_MODE=1 only, else 0)

Behaviour:
- Reset (async, rst_n low): in_ready=1, fft_go=0, rd_data=0, rd_busy=0, drop_cnt=0. Internal: wr_cnt=0, wr_bank=0, rd_bank=1, wr_full=0, state IDLE. Memory contents are not reset.
- Accept condition: in_valid & in_ready & !wr_full. An accepted sample is written to mem[{wr_bank, wr_cnt}] and wr_cnt increments, wrapping N-1 -> 0.
- Writing the sample at wr_cnt = N-1 completes the frame:
  - If rd_busy=0 or fft_done=1 in the same cycle: swap at that edge (rd_bank <= wr_bank, wr_bank flips, wr_cnt=0). fft_go=1 for exactly the next cycle. rd_busy=1 from that same next cycle.
  - Otherwise: set wr_full=1.
- While wr_full=1:
  - DROP_MODE=0: in_ready=0 (combinational from wr_full).
  - DROP_MODE=1: in_ready stays 1. Each in_valid cycle increments drop_cnt, saturating at 2^CNT_W-1; the sample is discarded.
- fft_done while rd_busy=1:
  - wr_full=1: swap at that edge, clear wr_full, fft_go pulses next cycle, rd_busy stays 1. in_ready returns to 1 in the cycle after the done.
  - wr_full=0: rd_busy clears at that edge.
- fft_done while rd_busy=0 is ignored.
- State machine (read side): IDLE -> GO (swap) -> BUSY (next cycle) -> IDLE on fft_done with no pending frame, or -> GO on fft_done with wr_full. fft_go=1 only in GO. rd_busy=1 in GO and BUSY.
- Read port: rd_data <= mem[{rd_bank, BITREV ? bitrev(rd_addr) : rd_addr}] on every edge regardless of state. Latency is exactly 1 clock. Data before the first fft_go is undefined.
- Widths: no arithmetic on samples. Data passes bit-exact.
- Reset mid-frame discards the partial frame. The first sample after release is index 0 of bank 0.

Decomposition:
- Shared package fft_pkg holds:
  - default constants FFT_DATA_W=8, FFT_LOG2_N=7
  - read-state encoding (IDLE, GO, BUSY)
  - a bit-reverse function parametrised on LOG2_N, reused by the FFT core's address generator.
- One sub-module: fft_dpram. It is a simple dual-port RAM, 2N x DATA_W, with one write port and one registered read port, so it can map onto block RAM.

Test Plan:
1. Defaults: stream ramp 0..127, one sample per cycle -> fft_go high for exactly one cycle, one clock after the 128th accepted sample. rd_addr=1 gives rd_data=64 a cycle later; rd_addr=127 gives 127.
2. BITREV=0: same ramp -> rd_addr=5 gives rd_data=5, one cycle later.
3. Backpressure: stream 0..255 with no fft_done -> in_ready falls the cycle after sample 255 is accepted. Pulse fft_done -> fft_go pulses the next cycle and in_ready returns to 1. rd_addr=0 gives rd_data=-128 (sample 128 as signed 8-bit).
4. DROP_MODE=1: as scenario 3, plus 10 extra valid samples before fft_done -> drop_cnt=10 and in_ready never falls. The next frame starts with the first sample after the done.
5. Simultaneous: frame 1's final sample is written in the same cycle as fft_done for frame 0 -> immediate swap, fft_go the next cycle, no stall cycle on in_ready.
6. Reset mid-frame: assert rst_n=0 after 50 samples, release, send 128 samples -> exactly one fft_go, drop_cnt=0, and the frame contains only post-reset data.
